// File: rtl/ds_link_pkg.sv
// ds_link_pkg -- shared definitions for the DS link transmit path.
//   tx_type_e : character type presented to the DS encoder
//   state_e   : transmit scheduler link state
//   req_id_e  : requester identity, used for round-robin memory
//   sel_e     : per-slot character selection inside the scheduler
//   FCT_CREDIT: characters of far-end buffer space announced by one FCT
package ds_link_pkg;

  typedef enum logic [1:0] {
    TYPE_NULL = 2'b00,
    TYPE_FCT  = 2'b01,
    TYPE_DATA = 2'b10
  } tx_type_e;

  typedef enum logic [1:0] {
    OFF = 2'b00,
    RUN = 2'b01,
    ERR = 2'b10
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    SEL_NULL = 2'b00,
    SEL_FCT  = 2'b01,
    SEL_A    = 2'b10,
    SEL_B    = 2'b11
  } sel_e;

  localparam int FCT_CREDIT = 8;
  localparam int FCT_PEND_W = 3;

endpackage

// File: rtl/link_tx_sched_if.sv
// link_tx_sched_if -- character request and encoder handshake bundle.
//   req_x/data_x/gnt_x : requester x offers data_x, gnt_x marks capture
//   tx_valid/tx_ready  : character presented to / accepted by the encoder
//   tx_type/tx_data    : character type and payload
// Modports: master = scheduler side, slave = requesters plus encoder.
interface link_tx_sched_if #(
  parameter int DATA_W = 8
);
  logic              req_a;
  logic [DATA_W-1:0] data_a;
  logic              gnt_a;
  logic              req_b;
  logic [DATA_W-1:0] data_b;
  logic              gnt_b;
  logic              tx_ready;
  logic              tx_valid;
  logic [1:0]        tx_type;
  logic [DATA_W-1:0] tx_data;

  modport master (
    input  req_a, data_a, req_b, data_b, tx_ready,
    output gnt_a, gnt_b, tx_valid, tx_type, tx_data
  );

  modport slave (
    output req_a, data_a, req_b, data_b, tx_ready,
    input  gnt_a, gnt_b, tx_valid, tx_type, tx_data
  );
endinterface

// File: rtl/credit_ctr.sv
// credit_ctr -- transmit credit counter with overflow detect.
//   clk, rst_n : clock, synchronous active-low reset
//   add8       : an FCT arrived, add FCT_CREDIT
//   sub1       : a data character is being sent, subtract one
//   clr        : link dropped, clear to zero
//   count      : current credit
//   ovf        : combinational; add8 would exceed CREDIT_MAX this cycle
// On overflow the FCT credit is discarded but a concurrent sub1 still applies.
module credit_ctr
  import ds_link_pkg::*;
#(
  parameter int CREDIT_MAX = 56,
  parameter int CREDIT_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                add8,
  input  logic                sub1,
  input  logic                clr,
  output logic [CREDIT_W-1:0] count,
  output logic                ovf
);

  // One bit wider so the trial sum cannot wrap before the compare.
  logic [CREDIT_W:0] trial;

  assign trial = {1'b0, count} + (CREDIT_W+1)'(FCT_CREDIT);
  assign ovf   = add8 && (trial > (CREDIT_W+1)'(CREDIT_MAX));

  // NOTE: reset is synchronous, so it lives inside the clocked branch and is
  // only seen on a rising edge; every state register uses <= so all flops
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (add8 && !ovf) begin
      count <= count + CREDIT_W'(FCT_CREDIT) - CREDIT_W'(sub1);
    end else if (sub1) begin
      count <= count - CREDIT_W'(1);
    end
  end

endmodule

// File: rtl/link_tx_sched.sv
// link_tx_sched -- picks one character per slot for the DS encoder:
// pending FCT first, then round-robin data from A/B while credit lasts,
// otherwise NULL. Tracks transmit credit from received FCTs.
//   clk, rst_n  : clock, synchronous active-low reset
//   link_up     : link state machine reports the link usable
//   fct_req     : pulse, local receiver freed space, queue one FCT
//   fct_rx      : pulse, far end sent an FCT, add credit
//   bus         : requester and encoder handshake (master modport)
//   credit      : current transmit credit
//   credit_err  : sticky credit overflow, cleared by a link drop
module link_tx_sched
  import ds_link_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CREDIT_MAX = 56,
  parameter int CREDIT_W   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                link_up,
  input  logic                fct_req,
  input  logic                fct_rx,
  link_tx_sched_if.master     bus,
  output logic [CREDIT_W-1:0] credit,
  output logic                credit_err
);

  state_e                state, state_n;
  req_id_e               last;
  sel_e                  sel;
  tx_type_e              tx_type_n;
  logic [DATA_W-1:0]     tx_data_n;
  logic [FCT_PEND_W-1:0] fct_pend;
  logic                  load, drop, ovf, fct_load, data_load;

  // The output register refills when empty or when its character is taken.
  assign load      = (state != OFF || link_up) && (!bus.tx_valid || bus.tx_ready);
  assign fct_load  = load && (sel == SEL_FCT);
  assign data_load = load && (sel == SEL_A || sel == SEL_B);

  // sel is only non-NULL in RUN, so grants need no separate state term.
  assign bus.gnt_a = rst_n && load && (sel == SEL_A);
  assign bus.gnt_b = rst_n && load && (sel == SEL_B);

  always_comb begin
    sel = SEL_NULL;
    if (state == RUN) begin
      if (fct_pend != '0) begin
        sel = SEL_FCT;
      end else if (credit != '0 && (bus.req_a || bus.req_b)) begin
        if (bus.req_a && bus.req_b) sel = (last == REQ_B) ? SEL_A : SEL_B;
        else                        sel = bus.req_a ? SEL_A : SEL_B;
      end
    end
  end

  always_comb begin
    tx_type_n = TYPE_NULL;
    tx_data_n = '0;
    case (sel)
      SEL_FCT: tx_type_n = TYPE_FCT;
      SEL_A:   begin tx_type_n = TYPE_DATA; tx_data_n = bus.data_a; end
      SEL_B:   begin tx_type_n = TYPE_DATA; tx_data_n = bus.data_b; end
      default: ;
    endcase
  end

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    drop    = 1'b0;
    case (state)
      OFF: if (link_up) state_n = RUN;
      RUN: begin
        if (!link_up) begin
          drop    = 1'b1;
          state_n = OFF;
        end else if (ovf) begin
          state_n = ERR;
        end
      end
      ERR: begin
        if (!link_up) begin
          drop    = 1'b1;
          state_n = OFF;
        end
      end
      default: state_n = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= OFF;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.tx_valid <= 1'b0;
      bus.tx_type  <= TYPE_NULL;
      bus.tx_data  <= '0;
      last         <= REQ_B;
    end else if (drop) begin
      bus.tx_valid <= 1'b0;
      last         <= REQ_B;
    end else if (load) begin
      bus.tx_valid <= 1'b1;
      bus.tx_type  <= tx_type_n;
      bus.tx_data  <= tx_data_n;
      if (sel == SEL_A) last <= REQ_A;
      if (sel == SEL_B) last <= REQ_B;
    end
  end

  // A request and a send in the same cycle cancel; a request at the
  // ceiling with no send is lost.
  always_ff @(posedge clk) begin
    if (!rst_n || drop) begin
      fct_pend <= '0;
    end else begin
      case ({fct_req, fct_load})
        2'b10:   if (fct_pend != '1) fct_pend <= fct_pend + FCT_PEND_W'(1);
        2'b01:   fct_pend <= fct_pend - FCT_PEND_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || drop) credit_err <= 1'b0;
    else if (ovf)       credit_err <= 1'b1;
  end

  // fct_rx is ignored while the link is OFF.
  credit_ctr #(
    .CREDIT_MAX (CREDIT_MAX),
    .CREDIT_W   (CREDIT_W)
  ) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .add8  (fct_rx && state != OFF),
    .sub1  (data_load),
    .clr   (drop),
    .count (credit),
    .ovf   (ovf)
  );

endmodule

// File: tb/tb_link_tx_sched.sv
// tb_link_tx_sched -- scoreboard bench for link_tx_sched. Each slot the
// bench pushes the character it expects to be loaded; a negedge monitor
// pops and compares whenever the encoder accepts a character.
module tb_link_tx_sched;
  import ds_link_pkg::*;

  typedef struct packed {
    logic [1:0] ty;
    logic [7:0] d;
  } chr_t;

  logic       clk = 1'b0;
  logic       rst_n, link_up, fct_req, fct_rx;
  logic [5:0] credit;
  logic       credit_err;

  int   n_cmp = 0;
  int   n_err = 0;
  chr_t sb_q[$];
  chr_t mon_e;
  logic [1:0] last_ty;
  logic [7:0] last_d;

  link_tx_sched_if #(.DATA_W(8)) bus ();

  link_tx_sched #(
    .DATA_W     (8),
    .CREDIT_MAX (56),
    .CREDIT_W   (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .link_up    (link_up),
    .fct_req    (fct_req),
    .fct_rx     (fct_rx),
    .bus        (bus),
    .credit     (credit),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One loading slot with tx_ready high: queue the expected character,
  // check the grants, clock, and let a granted requester advance.
  task automatic tick(input logic [1:0] ty, input logic [7:0] d,
                      input logic ega, input logic egb);
    sb_q.push_back({ty, d});
    #1;
    check("gnt_a", 32'(bus.gnt_a), 32'(ega));
    check("gnt_b", 32'(bus.gnt_b), 32'(egb));
    @(posedge clk); #1;
    if (ega) bus.data_a = bus.data_a + 8'd1;
    if (egb) bus.data_b = bus.data_b + 8'd1;
    last_ty = ty;
    last_d  = d;
  endtask

  // A slot in which nothing new is expected to be loaded.
  task automatic idle_step();
    #1;
    check("idle_gnt_a", 32'(bus.gnt_a), 32'd0);
    check("idle_gnt_b", 32'(bus.gnt_b), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_char", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_tx_type", 32'(bus.tx_type), 32'(mon_e.ty));
        check("sb_tx_data", 32'(bus.tx_data), 32'(mon_e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    link_up      = 1'b1;
    fct_req      = 1'b0;
    fct_rx       = 1'b0;
    bus.req_a    = 1'b1;
    bus.req_b    = 1'b1;
    bus.data_a   = 8'hA0;
    bus.data_b   = 8'hB0;
    bus.tx_ready = 1'b1;

    // Reset: outputs at reset values, grants held low with requests up.
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt_a", 32'(bus.gnt_a), 32'd0);
    check("rst_gnt_b", 32'(bus.gnt_b), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_type", 32'(bus.tx_type), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_credit_err", 32'(credit_err), 32'd0);
    link_up = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;
    check("off_tx_valid", 32'(bus.tx_valid), 32'd0);

    // Link start with no credit: NULLs only.
    link_up = 1'b1;
    repeat (4) tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    check("start_credit", 32'(credit), 32'd0);

    // Credit release: 8 data characters alternating A,B.
    fct_rx = 1'b1;
    tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    fct_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("release_credit", 32'(credit), 32'(8 - i));
      if (i % 2 == 0) tick(TYPE_DATA, bus.data_a, 1'b1, 1'b0);
      else            tick(TYPE_DATA, bus.data_b, 1'b0, 1'b1);
    end
    check("release_credit_end", 32'(credit), 32'd0);
    repeat (2) tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);

    // Build credit 16 with no requests.
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    fct_rx    = 1'b1;
    repeat (2) tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    fct_rx = 1'b0;
    check("credit_16", 32'(credit), 32'd16);

    // FCT priority: two FCT requests beat a pending data request.
    fct_req = 1'b1;
    tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    bus.req_a = 1'b1;
    tick(TYPE_FCT, 8'h00, 1'b0, 1'b0);
    fct_req = 1'b0;
    tick(TYPE_FCT, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) tick(TYPE_DATA, bus.data_a, 1'b1, 1'b0);
    check("credit_5", 32'(credit), 32'd5);

    // Simultaneous FCT receive and data send: 5 + 8 - 1.
    fct_rx = 1'b1;
    tick(TYPE_DATA, bus.data_a, 1'b1, 1'b0);
    fct_rx = 1'b0;
    check("credit_simul", 32'(credit), 32'd12);

    // Bring credit to 50.
    repeat (2) tick(TYPE_DATA, bus.data_a, 1'b1, 1'b0);
    bus.req_a = 1'b0;
    fct_rx    = 1'b1;
    repeat (5) tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    check("credit_50", 32'(credit), 32'd50);
    check("err_before_ovf", 32'(credit_err), 32'd0);

    // Overflow: credit held, flag set, ERR sends only NULL.
    tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    fct_rx = 1'b0;
    check("ovf_credit", 32'(credit), 32'd50);
    check("ovf_credit_err", 32'(credit_err), 32'd1);
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    fct_req   = 1'b1;
    tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    fct_req = 1'b0;
    repeat (2) tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    check("err_credit", 32'(credit), 32'd50);

    // Link drop clears everything.
    link_up = 1'b0;
    idle_step();
    check("drop_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("drop_credit", 32'(credit), 32'd0);
    check("drop_credit_err", 32'(credit_err), 32'd0);
    idle_step();
    check("off_tx_valid2", 32'(bus.tx_valid), 32'd0);

    // Relink: NULL first, fct_rx in OFF ignored, FCT queue empty, A first.
    link_up = 1'b1;
    fct_rx  = 1'b1;
    tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    fct_rx = 1'b0;
    check("off_fct_rx_ignored", 32'(credit), 32'd0);
    tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    fct_rx = 1'b1;
    tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);
    fct_rx = 1'b0;
    tick(TYPE_DATA, bus.data_a, 1'b1, 1'b0);
    tick(TYPE_DATA, bus.data_b, 1'b0, 1'b1);
    check("relink_credit", 32'(credit), 32'd6);

    // Backpressure: character held, no grants.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle_step();
      check("hold_tx_valid", 32'(bus.tx_valid), 32'd1);
      check("hold_tx_type", 32'(bus.tx_type), 32'(last_ty));
      check("hold_tx_data", 32'(bus.tx_data), 32'(last_d));
    end
    bus.tx_ready = 1'b1;
    tick(TYPE_DATA, bus.data_a, 1'b1, 1'b0);
    check("resume_credit", 32'(credit), 32'd5);

    // Mid-run reset with a DATA character presented.
    check("pre_rst_tx_valid", 32'(bus.tx_valid), 32'd1);
    rst_n = 1'b0;
    idle_step();
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("mid_rst_tx_type", 32'(bus.tx_type), 32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("mid_rst_credit", 32'(credit), 32'd0);
    check("mid_rst_credit_err", 32'(credit_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick(TYPE_NULL, 8'h00, 1'b0, 1'b0);

    // Drain: the last presented character is taken, then nothing remains.
    link_up = 1'b0;
    idle_step();
    idle_step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/link_tx_sched.md
# link_tx_sched

Transmit scheduler for the IEEE 1355 data-strobe link in `node`. It sits between the character sources (switch-driven requester A, button-driven requester B) and the DS character encoder. Each character slot it picks one character: a flow-control token (FCT), a data character or a NULL filler. It also tracks transmit credit from received FCTs, so data is sent only when the far end has buffer space.

## Interface
- `DATA_W`, 8, data character width
- `CREDIT_MAX`, 56, credit ceiling (7 FCTs × 8 characters)
- `CREDIT_W`, 6, credit counter width
- `clk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  reset: synchronous, active-low
- `link_up`  in  1  from the link state machine; low means the link is down
- `req_a`  in  1  requester A has a character
- `data_a`  in  DATA_W  requester A character; held stable while `req_a` is high
- `gnt_a`  out  1  combinational; high in the cycle A's character is captured
- `req_b`, `data_b`, `gnt_b`  same as A, for requester B
- `fct_req`  in  1  one-cycle pulse: the local receiver has freed 8 slots, so send one FCT
- `fct_rx`  in  1  one-cycle pulse: an FCT was received from the far end, adding 8 credit
- `tx_ready`  in  1  encoder accepts the character on `tx_type`/`tx_data` this cycle
- `tx_valid`  out  1  registered; a character is presented
- `tx_type`  out  2  registered; 00 NULL, 01 FCT, 10 DATA (11 unused)
- `tx_data`  out  DATA_W  registered; payload when `tx_type`=DATA, otherwise 0
- `credit`  out  CREDIT_W  current transmit credit
- `credit_err`  out  1  sticky credit-overflow flag

## Operation
- **Load condition:** `load = (state!=OFF || link_up) && (!tx_valid || tx_ready)`. On a load edge the output register takes the selected character.
- **States:**
  - **OFF** (reset state). `tx_valid`=0. If `link_up`=1, load NULL and go to RUN. Every transmission after link-up therefore starts with a NULL.
  - **RUN.** Selection priority on load:
    1. FCT, if `fct_pend`>0.
    2. DATA, if `credit`>0 and any request is high. Round-robin: if both requests are high, grant the requester not served last. `last` resets to B, so A wins first.
    3. NULL otherwise.
  - **ERR.** Entered on credit overflow. Every load is NULL; no grants, no FCTs.
  - **Link drop.** RUN/ERR → OFF whenever `link_up`=0. On that edge: `tx_valid`←0, `credit`←0, `fct_pend`←0, `credit_err`←0, `last`←B. Leaving ERR is only through OFF.
- **Grants:** `gnt_x = load && state==RUN && selected==x`. A requester advances on that edge.
- **`fct_pend` (3 bits):**
  - +1 on `fct_req`, −1 on an FCT load; both in one cycle leaves it unchanged.
  - A `fct_req` arriving at 7 is dropped.
- **`credit`:**
  - +8 on `fct_rx`, −1 on a DATA load; both in one cycle gives +7.
  - If `fct_rx` would push credit above CREDIT_MAX: credit unchanged, `credit_err`←1, state→ERR (the DATA decrement in that cycle still applies).
  - `fct_rx` in OFF is ignored.
- **Reset:** `rst_n`=0 on any edge forces OFF, `tx_valid`=0, `tx_type`=00, `tx_data`=0, `credit`=0, `fct_pend`=0, `credit_err`=0, `last`=B. Reset mid-character aborts it and nothing is replayed. Grants are 0 during reset.

## Timing
- A character is presented on the edge after its load decision; `tx_valid` stays high until `tx_ready`.
- Back-to-back: if `tx_ready` is high every cycle, one new character per cycle. The encoder normally throttles to one per character time.
- `gnt_x` depends combinationally on `tx_ready`, `req_x`, `credit`, `fct_pend` and state. No path from `tx_ready` reaches `tx_valid` combinationally.
- `credit` and `credit_err` are registered and update one edge after the event.

## Structure
- Shared package (`ds_link_pkg`) holds:
  - the `tx_type` encodings TYPE_NULL/TYPE_FCT/TYPE_DATA;
  - the FSM state encoding OFF/RUN/ERR;
  - the FCT_CREDIT=8 constant.
- One sub-module is natural: `credit_ctr`, the saturating credit counter with overflow detect (inputs `add8`, `sub1`, `clr`; outputs `count`, `ovf`).

## Test plan
- **Link start:** reset, `link_up`=1, `tx_ready`=1, both requests high, credit 0 → NULL first, then NULLs only; `gnt_a`=`gnt_b`=0.
- **Credit release:** one `fct_rx` pulse with A and B held high → exactly 8 DATA characters, alternating A,B,A,B… (A first); `credit` steps 8→0; NULLs follow.
- **FCT priority:** `fct_req` ×2 while credit=16 and A requesting → next two loads are FCT, then DATA; `fct_pend` 2→0.
- **Simultaneous update:** `fct_rx` on the same cycle as a DATA load at credit=5 → credit 12.
- **Overflow:** credit=50 plus `fct_rx` → `credit_err`=1, credit stays 50, only NULLs follow; dropping `link_up` clears the flag, credit goes to 0, `tx_valid`=0.
- **Mid-run reset:** `rst_n`=0 for one edge while `tx_valid`=1 with a DATA character presented → all outputs at reset values next cycle; the first character after `link_up` is NULL.
